// File: rtl/gol_generation_sequencer.sv
// Sequences the Game-of-Life step engine for a host-programmed number of generations,
// ping-ponging the board buffers and exposing control/status over a 2-bit Avalon-MM slave.
module gol_generation_sequencer #(
  parameter int unsigned GEN_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        step_start,
  input  logic        step_done,
  output logic        buf_sel,
  output logic        completed
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StSwap, StDone} state_e;

  state_e             state_q;
  logic [GEN_W-1:0]   target_q;
  logic [GEN_W-1:0]   gen_cnt_q;
  logic [GEN_W-1:0]   gen_inc;
  logic               aborted_q;
  logic               abort_pend_q;
  logic               step_start_q;
  logic               buf_sel_q;
  logic               completed_q;
  logic [31:0]        readdata_q;
  logic [31:0]        rd_mux;

  logic busy;
  logic wr_ctrl;
  logic start_req;
  logic abort_req;
  logic wr_target;
  logic unused_inputs;

  assign busy      = (state_q == StIssue) || (state_q == StWait) || (state_q == StSwap);
  assign wr_ctrl   = write && (address == 2'd0);
  assign abort_req = wr_ctrl && writedata[1];
  assign start_req = wr_ctrl && writedata[0];
  assign wr_target = write && (address == 2'd1);
  assign gen_inc   = gen_cnt_q + GEN_W'(1);

  // Reads are unconditional; the strobe exists only for bus compatibility.
  assign unused_inputs = ^{read, writedata};

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0: rd_mux[0] = busy;
      2'd1: rd_mux[GEN_W-1:0] = target_q;
      2'd2: rd_mux[GEN_W-1:0] = gen_cnt_q;
      default: rd_mux[3:0] = {aborted_q, buf_sel_q, completed_q, busy};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      target_q     <= '0;
      gen_cnt_q    <= '0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      step_start_q <= 1'b0;
      buf_sel_q    <= 1'b0;
      completed_q  <= 1'b0;
      readdata_q   <= '0;
    end else begin
      step_start_q <= 1'b0;
      readdata_q   <= rd_mux;
      if (wr_target && !busy) target_q <= writedata[GEN_W-1:0];

      case (state_q)
        StIdle, StDone: begin
          if (abort_req) begin
            completed_q <= 1'b0;
          end else if (start_req) begin
            completed_q  <= 1'b0;
            gen_cnt_q    <= '0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            if (target_q == '0) begin
              state_q     <= StDone;
              completed_q <= 1'b1;
            end else begin
              state_q      <= StIssue;
              step_start_q <= 1'b1;
            end
          end
        end
        StIssue: begin
          state_q <= StWait;
          if (abort_req) abort_pend_q <= 1'b1;
        end
        StWait: begin
          // The engine is never cut off; an abort only takes effect once it reports done.
          if (step_done) begin
            if (abort_pend_q || abort_req) begin
              state_q      <= StIdle;
              aborted_q    <= 1'b1;
              abort_pend_q <= 1'b0;
            end else begin
              state_q <= StSwap;
            end
          end else if (abort_req) begin
            abort_pend_q <= 1'b1;
          end
        end
        StSwap: begin
          buf_sel_q <= ~buf_sel_q;
          gen_cnt_q <= gen_inc;
          if (abort_pend_q || abort_req) begin
            state_q      <= StIdle;
            aborted_q    <= 1'b1;
            abort_pend_q <= 1'b0;
          end else if (gen_inc == target_q) begin
            state_q     <= StDone;
            completed_q <= 1'b1;
          end else begin
            state_q      <= StIssue;
            step_start_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign readdata   = readdata_q;
  assign step_start = step_start_q;
  assign buf_sel    = buf_sel_q;
  assign completed  = completed_q;

endmodule

// File: tb/tb_gol_generation_sequencer.sv
// Bench for gol_generation_sequencer: an engine responder plus a run-level model of
// generation count, buffer parity and status flags.
module tb_gol_generation_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        step_start;
  logic        step_done = 1'b0;
  logic        buf_sel;
  logic        completed;

  gol_generation_sequencer #(.GEN_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .write      (write),
    .writedata  (writedata),
    .read       (read),
    .readdata   (readdata),
    .step_start (step_start),
    .step_done  (step_done),
    .buf_sel    (buf_sel),
    .completed  (completed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pulses = 0;
  int n_double = 0;
  logic ss_prev = 1'b0;
  int lat_cfg  = 5;
  int eng_cnt  = 0;
  logic eng_busy = 1'b0;

  // Run-level model state
  int m_buf, m_gen, m_abort, m_comp, m_target;

  always @(posedge clk) begin
    if (step_start) n_pulses <= n_pulses + 1;
    if (step_start && ss_prev) n_double <= n_double + 1;
    ss_prev <= step_start;
  end

  // Engine responder: one step_done pulse a configurable number of cycles after step_start
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_done <= 1'b0;
      eng_busy  <= 1'b0;
      eng_cnt   <= 0;
    end else begin
      step_done <= 1'b0;
      if (eng_busy) begin
        if (eng_cnt <= 1) begin
          step_done <= 1'b1;
          eng_busy  <= 1'b0;
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
      end
      if (step_start) begin
        eng_busy <= 1'b1;
        eng_cnt  <= lat_cfg;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] status_exp();
    return 32'(m_abort * 8 + m_buf * 4 + m_comp * 2);
  endfunction

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    address = addr; writedata = data; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    address = addr; read = 1'b1;
    @(negedge clk);
    data = readdata;
    read = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int k;
    s = 32'h1;
    k = 0;
    while (s[0] && k < 400) begin
      bus_read(2'd3, s);
      k++;
    end
    check({tag, "_idle"}, {31'b0, s[0]}, 32'h0);
  endtask

  task automatic wait_pulses(input string tag, input int want);
    int k;
    k = 0;
    while (n_pulses < want && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_reach"}, 32'(n_pulses >= want), 32'h1);
  endtask

  task automatic run_and_check(input string tag, input int t, input int lat);
    logic [31:0] d;
    int p0;
    lat_cfg = lat;
    bus_write(2'd1, 32'(t));
    p0 = n_pulses;
    bus_write(2'd0, 32'h1);
    wait_idle(tag);
    repeat (3) @(negedge clk);
    m_target = t; m_gen = t; m_buf = m_buf ^ (t & 1); m_comp = 1; m_abort = 0;
    check({tag, "_pulses"}, 32'(n_pulses - p0), 32'(t));
    bus_read(2'd2, d);
    check({tag, "_gen_cnt"}, d, 32'(m_gen));
    check({tag, "_buf_sel"}, {31'b0, buf_sel}, 32'(m_buf));
    check({tag, "_completed"}, {31'b0, completed}, 32'h1);
    bus_read(2'd3, d);
    check({tag, "_status"}, d, status_exp());
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  acc;
    int p0;

    reset_n = 1'b0; address = 2'd0; write = 1'b0; writedata = 32'h0; read = 1'b0;
    m_buf = 0; m_gen = 0; m_abort = 0; m_comp = 0; m_target = 0;

    // 1: reset with random bus activity
    acc = 4'h0;
    repeat (10) begin
      @(negedge clk);
      address = 2'($urandom); write = 1'($urandom); writedata = $urandom; read = 1'($urandom);
      @(posedge clk); #1;
      acc = acc | {readdata != 32'h0, step_start, buf_sel, completed};
    end
    check("rst_outputs", {28'b0, acc}, 32'h0);
    @(negedge clk);
    address = 2'd0; write = 1'b0; read = 1'b0; reset_n = 1'b1;
    bus_read(2'd3, d); check("rst_status", d, 32'h0);
    bus_read(2'd1, d); check("rst_target", d, 32'h0);
    bus_read(2'd2, d); check("rst_gen_cnt", d, 32'h0);

    // 2: three generations, fixed engine latency
    run_and_check("t3_run", 3, 5);
    bus_read(2'd1, d); check("t3_target_rd", d, 32'h3);

    // 3: zero target completes at once without stepping
    bus_write(2'd1, 32'h0);
    p0 = n_pulses;
    bus_write(2'd0, 32'h1);
    @(negedge clk);
    m_gen = 0; m_comp = 1; m_abort = 0;
    check("t0_completed", {31'b0, completed}, 32'h1);
    check("t0_pulses", 32'(n_pulses - p0), 32'h0);
    bus_read(2'd2, d); check("t0_gen_cnt", d, 32'h0);
    bus_read(2'd3, d); check("t0_status", d, status_exp());

    // 4: abort while waiting on the second generation
    lat_cfg = 5;
    bus_write(2'd1, 32'h5);
    p0 = n_pulses;
    bus_write(2'd0, 32'h1);
    wait_pulses("abort", p0 + 2);
    bus_write(2'd0, 32'h2);
    wait_idle("abort");
    repeat (20) @(negedge clk);
    m_gen = 1; m_buf = m_buf ^ 1; m_abort = 1; m_comp = 0;
    check("abort_pulses", 32'(n_pulses - p0), 32'h2);
    bus_read(2'd2, d); check("abort_gen_cnt", d, 32'(m_gen));
    bus_read(2'd3, d); check("abort_status", d, status_exp());
    check("abort_completed", {31'b0, completed}, 32'h0);

    // 5: target and start writes while busy are ignored
    lat_cfg = 5;
    bus_write(2'd1, 32'h4);
    p0 = n_pulses;
    bus_write(2'd0, 32'h1);
    bus_write(2'd1, 32'h9);
    bus_write(2'd0, 32'h1);
    wait_idle("busy_wr");
    repeat (5) @(negedge clk);
    m_gen = 4; m_comp = 1; m_abort = 0;
    bus_read(2'd1, d); check("busy_target_rd", d, 32'h4);
    check("busy_pulses", 32'(n_pulses - p0), 32'h4);
    bus_read(2'd2, d); check("busy_gen_cnt", d, 32'(m_gen));
    bus_read(2'd3, d); check("busy_status", d, status_exp());
    // abort in DONE only clears completed
    bus_write(2'd0, 32'h2);
    m_comp = 0;
    check("done_abort_completed", {31'b0, completed}, 32'h0);
    bus_read(2'd3, d); check("done_abort_status", d, status_exp());

    // randomized runs
    for (int i = 0; i < 6; i++) begin
      run_and_check($sformatf("rnd%0d", i), int'($urandom_range(1, 7)), int'($urandom_range(1, 6)));
    end

    // 6: asynchronous reset in the middle of a run
    lat_cfg = 5;
    bus_write(2'd1, 32'h3);
    p0 = n_pulses;
    bus_write(2'd0, 32'h1);
    wait_pulses("midrst", p0 + 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_outputs", {28'b0, readdata != 32'h0, step_start, buf_sel, completed}, 32'h0);
    m_buf = 0; m_gen = 0; m_abort = 0; m_comp = 0; m_target = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd3, d); check("midrst_status", d, status_exp());
    bus_read(2'd1, d); check("midrst_target", d, 32'h0);
    run_and_check("post_rst", 1, 4);

    check("single_cycle_pulses", 32'(n_double), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
